lp_printer_sink: RTL and testbench



---
 rtl/lp_sink_pkg.sv | 22 ++
 rtl/lp_sink_fifo.sv | 52 +++++
 rtl/lp_printer_sink.sv | 141 ++++++++++++++
 tb/tb_lp_printer_sink.sv | 284 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lp_sink_pkg.sv
// Shared definitions for the parallel-port printer sink: FSM state
// encoding, counter width and default parameter values.
package lp_sink_pkg;

  // Handshake FSM states
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    STALL   = 3'd1,
    CAPTURE = 3'd2,
    HOLD    = 3'd3,
    ACK     = 3'd4
  } state_t;

  // Width of the shared HOLD/ACK cycle counter
  localparam int CNT_W = 16;

  // Default parameter values
  localparam int DEF_FIFO_DEPTH  = 16;
  localparam int DEF_HOLD_CYCLES = 32;
  localparam int DEF_ACK_CYCLES  = 8;

endpackage

// File: rtl/lp_sink_fifo.sv
// Show-ahead byte FIFO for the printer sink. Pointers carry one extra
// bit so that full (occupancy == DEPTH) and empty are distinguishable.
// rd_data reads as zero while the FIFO is empty.
module lp_sink_fifo
  import lp_sink_pkg::*;
#(
  parameter int DEPTH  = DEF_FIFO_DEPTH,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              push,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              full
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              empty;
  logic              do_push;
  logic              do_pop;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign rd_valid = !empty;
  assign rd_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

  // Pointer update; both may advance in the same cycle, leaving occupancy unchanged
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; contents are not reset, pointers define validity
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

endmodule

// File: rtl/lp_printer_sink.sv
// Centronics-style printer sink. Detects the host strobe, captures the
// byte into a FIFO, holds busy for HOLD_CYCLES clocks (counted from the
// capture cycle) and then issues an ACK_CYCLES-wide active-low ACK.
// HOLD_CYCLES must be at least 2 and ACK_CYCLES at least 1.
// Optional feature: define LP_SINK_PAPER_ERROR_EN to report paper-out on
// lp_error_n / lp_det and refuse strobes while out of paper.
module lp_printer_sink
  import lp_sink_pkg::*;
#(
  parameter int FIFO_DEPTH  = DEF_FIFO_DEPTH,
  parameter int HOLD_CYCLES = DEF_HOLD_CYCLES,
  parameter int ACK_CYCLES  = DEF_ACK_CYCLES
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] lp_data,
  input  logic       lp_strobe_n,
  output logic       lp_ack_n,
  output logic       lp_busy,
  output logic       lp_error_n,
  output logic [1:0] lp_det,
  input  logic       online,
  input  logic       paper_out,
  input  logic       rd_en,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  output logic       overrun
);

  state_t           state;
  state_t           state_nxt;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             strobe_n_p1;
  logic [7:0]       data_p1;
  logic             strobe_seen;
  logic             paper_block;
  logic             accept;
  logic             drop;
  logic             push;
  logic             fifo_full;

`ifdef LP_SINK_PAPER_ERROR_EN
  assign paper_block = paper_out;
  assign lp_error_n  = ~paper_out;
  assign lp_det      = {2{paper_out}};
`else
  assign paper_block = paper_out & 1'b0;
  assign lp_error_n  = 1'b1;
  assign lp_det      = 2'b00;
`endif

  // Falling edge of the strobe relative to its registered history
  assign strobe_seen = !lp_strobe_n && strobe_n_p1;
  assign accept      = strobe_seen && (state == IDLE) && online && !paper_block;
  assign drop        = strobe_seen && ((state != IDLE) || paper_block);

  // Strobe history register
  always_ff @(posedge clk) begin
    if (reset) strobe_n_p1 <= 1'b1;
    else       strobe_n_p1 <= lp_strobe_n;
  end

  // Byte latch, loaded only when the strobe is accepted
  always_ff @(posedge clk) begin
    if (accept) data_p1 <= lp_data;
  end

  // State, counter and sticky overrun flag
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      if (drop) overrun <= 1'b1;
    end
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    push      = 1'b0;
    lp_busy   = 1'b1;
    lp_ack_n  = 1'b1;
    case (state)
      IDLE: begin
        lp_busy = 1'b0;
        if (accept) state_nxt = fifo_full ? STALL : CAPTURE;
      end
      STALL: begin
        if (!fifo_full) state_nxt = CAPTURE;
      end
      CAPTURE: begin
        push      = 1'b1;
        cnt_nxt   = '0;
        state_nxt = HOLD;
      end
      HOLD: begin
        // CAPTURE counts as the first busy cycle of the hold period
        if (cnt == CNT_W'(HOLD_CYCLES - 2)) begin
          cnt_nxt   = '0;
          state_nxt = ACK;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      ACK: begin
        lp_ack_n = 1'b0;
        if (cnt == CNT_W'(ACK_CYCLES - 1)) begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  lp_sink_fifo #(
    .DEPTH  (FIFO_DEPTH),
    .DATA_W (8)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .wr_data  (data_p1),
    .pop      (rd_en),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .full     (fifo_full)
  );

endmodule

// File: tb/tb_lp_printer_sink.sv
// Bench for lp_printer_sink: directed strobes with expected bytes queued
// as they are sent; a monitor pops and compares on every FIFO read.
module tb_lp_printer_sink;

  localparam int DEPTH = 16;
  localparam int HOLD  = 32;
  localparam int ACKW  = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] lp_data = 8'h00;
  logic       lp_strobe_n = 1'b1;
  logic       online = 1'b1;
  logic       paper_out = 1'b0;
  logic       rd_en = 1'b0;
  logic       lp_ack_n;
  logic       lp_busy;
  logic       lp_error_n;
  logic [1:0] lp_det;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       overrun;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] exp_q[$];

  lp_printer_sink #(
    .FIFO_DEPTH  (DEPTH),
    .HOLD_CYCLES (HOLD),
    .ACK_CYCLES  (ACKW)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .lp_data     (lp_data),
    .lp_strobe_n (lp_strobe_n),
    .lp_ack_n    (lp_ack_n),
    .lp_busy     (lp_busy),
    .lp_error_n  (lp_error_n),
    .lp_det      (lp_det),
    .online      (online),
    .paper_out   (paper_out),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted read is compared with the scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (!reset && rd_valid && rd_en) begin
        if (exp_q.size() == 0) check("scoreboard depth at pop", exp_q.size(), 1);
        else                   check("rd_data", rd_data, exp_q.pop_front());
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] d);
    lp_data = d;
    lp_strobe_n = 1'b0;
    tick(1);
    lp_strobe_n = 1'b1;
  endtask

  // cyc is the cycle index relative to the strobe cycle when ACK first goes low
  task automatic wait_ack_start(input int start, output int cyc);
    cyc = start;
    while (lp_ack_n === 1'b1 && cyc < 400) begin
      tick(1);
      cyc++;
    end
  endtask

  task automatic wait_ack_end(output int w);
    w = 0;
    while (lp_ack_n === 1'b0 && w < 100) begin
      w++;
      tick(1);
    end
  endtask

  task automatic send(input logic [7:0] d);
    int c;
    int w;
    strobe(d);
    exp_q.push_back(d);
    check("busy in capture", lp_busy, 1);
    wait_ack_start(1, c);
    check("strobe to ack latency", c, HOLD + 1);
    check("busy during ack", lp_busy, 1);
    wait_ack_end(w);
    check("ack width", w, ACKW);
    check("busy after ack", lp_busy, 0);
  endtask

  task automatic pop_one();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    exp_q.delete();
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    int c;
    int w;
    int bad;

    // Reset state
    tick(2);
    check("reset ack_n", lp_ack_n, 1);
    check("reset busy", lp_busy, 0);
    check("reset error_n", lp_error_n, 1);
    check("reset det", lp_det, 0);
    check("reset rd_valid", rd_valid, 0);
    check("reset rd_data", rd_data, 8'h00);
    check("reset overrun", overrun, 0);
    reset = 1'b0;
    tick(1);

    // Single byte 0x41
    send(8'h41);
    check("rd_valid after 0x41", rd_valid, 1);
    check("rd_data head 0x41", rd_data, 8'h41);
    pop_one();
    check("empty after pop", rd_valid, 0);

    // Offline strobe is discarded silently
    online = 1'b0;
    strobe(8'h55);
    check("offline busy", lp_busy, 0);
    bad = 0;
    repeat (40) begin
      if (lp_ack_n !== 1'b1 || lp_busy !== 1'b0) bad++;
      tick(1);
    end
    check("offline no ack/busy", bad, 0);
    check("offline rd_valid", rd_valid, 0);
    check("offline overrun", overrun, 0);
    online = 1'b1;

    // Second strobe during HOLD is dropped and flags overrun
    strobe(8'h11);
    exp_q.push_back(8'h11);
    tick(5);
    strobe(8'h22);
    check("overrun after hold strobe", overrun, 1);
    wait_ack_start(7, c);
    check("first ack latency kept", c, HOLD + 1);
    wait_ack_end(w);
    check("first ack width kept", w, ACKW);
    check("overrun sticky", overrun, 1);
    pop_one();
    check("dropped byte not stored", rd_valid, 0);
    do_reset();
    check("overrun cleared by reset", overrun, 0);

    // Read while empty is ignored
    rd_en = 1'b1;
    tick(2);
    rd_en = 1'b0;
    check("empty read ignored", rd_valid, 0);
    send(8'h7E);
    check("head after empty read", rd_data, 8'h7E);
    pop_one();

    // Push and pop in the same cycle
    send(8'hA1);
    strobe(8'hA2);
    exp_q.push_back(8'hA2);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("push+pop valid", rd_valid, 1);
    check("push+pop head", rd_data, 8'hA2);
    wait_ack_start(2, c);
    check("push+pop ack latency", c, HOLD + 1);
    wait_ack_end(w);
    pop_one();
    check("push+pop drained", rd_valid, 0);

    // Fill the FIFO, then a 17th strobe stalls until one read
    for (int i = 0; i < DEPTH; i++) send(8'h80 + 8'(i));
    strobe(8'h99);
    check("stall busy", lp_busy, 1);
    bad = 0;
    repeat (50) begin
      if (lp_busy !== 1'b1 || lp_ack_n !== 1'b1) bad++;
      tick(1);
    end
    check("stall held", bad, 0);
    check("stall head", rd_data, 8'h80);
    exp_q.push_back(8'h99);
    pop_one();
    wait_ack_start(1, c);
    check("stall release ack latency", c, HOLD + 2);
    wait_ack_end(w);
    check("stall ack width", w, ACKW);
    check("stall overrun", overrun, 0);
    rd_en = 1'b1;
    tick(DEPTH);
    rd_en = 1'b0;
    check("drained after stall", rd_valid, 0);
    check("scoreboard empty after drain", exp_q.size(), 0);

    // Reset during ACK
    strobe(8'h33);
    exp_q.push_back(8'h33);
    tick(3);
    strobe(8'h44);
    wait_ack_start(5, c);
    tick(2);
    check("in ack before reset", lp_ack_n, 0);
    reset = 1'b1;
    exp_q.delete();
    tick(1);
    reset = 1'b0;
    check("ack_n after reset", lp_ack_n, 1);
    check("busy after reset", lp_busy, 0);
    check("rd_valid after reset", rd_valid, 0);
    check("overrun after reset", overrun, 0);
    tick(1);
    send(8'h5A);
    pop_one();

    // Paper-out handling
    paper_out = 1'b1;
    tick(1);
`ifdef LP_SINK_PAPER_ERROR_EN
    check("paper error_n", lp_error_n, 0);
    check("paper det", lp_det, 2'b11);
    strobe(8'h66);
    check("paper strobe overrun", overrun, 1);
    check("paper strobe busy", lp_busy, 0);
    bad = 0;
    repeat (40) begin
      if (lp_ack_n !== 1'b1) bad++;
      tick(1);
    end
    check("paper no ack", bad, 0);
    check("paper no push", rd_valid, 0);
    paper_out = 1'b0;
    tick(1);
    check("paper cleared error_n", lp_error_n, 1);
    check("paper cleared det", lp_det, 0);
`else
    check("paper ignored error_n", lp_error_n, 1);
    check("paper ignored det", lp_det, 0);
    send(8'h66);
    check("paper ignored capture", rd_data, 8'h66);
    pop_one();
    check("paper ignored overrun", overrun, 0);
    paper_out = 1'b0;
`endif

    tick(2);
    check("scoreboard empty at end", exp_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
